ppu_bus_arbiter: RTL

- Arbitrates the single shared video-memory bus (VRAM 8000-9FFF, OAM FE00-FE9F, and DMA source space) between three requesters: the PPU fetch engine, the CPU, and an internal OAM DMA engine.
- Enforces CPU lockouts by PPU mode.
- Owns the DMA register at FF46 and sequences the 160-byte OAM copy.
- Sits between the CPU MMIO bus, the PPU's PPU_RD/PPU_ADDR/PPU_DATA_in port, and the memory system.

---
 rtl/ppu_bus_arbiter.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/ppu_bus_arbiter.sv
// ppu_bus_arbiter: shared video-memory bus arbiter with OAM DMA engine.
// Grants the bus each cycle in this order: DMA, then PPU fetch, then CPU.
// It applies CPU lockouts, owns the DMA trigger register and copies
// DMA_LEN bytes into OAM.
// Build option: define PPU_ACCESS_LOCK_EN to block CPU access to OAM and
// VRAM according to the PPU mode. Without it (bring-up builds) only
// arbitration loss and the DMA HRAM-only rule restrict the CPU.
//
// DMA states:
//   state    | meaning
//   ---------+-------------------------------------------------
//   ST_IDLE  | no copy in progress
//   ST_START | one dead cycle after trigger, dma_active already high
//   ST_READ  | fetch source byte {src_hi, idx} into dbuf
//   ST_WRITE | store dbuf to OAM_BASE + idx, advance or finish

module ppu_bus_arbiter #(
  parameter int          DMA_LEN      = 160,
  parameter logic [15:0] OAM_BASE     = 16'hFE00,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_wait,
  input  logic [1:0]  ppu_mode,
  input  logic        ppu_rd,
  input  logic [15:0] ppu_addr,
  output logic [7:0]  ppu_rdata,
  output logic [15:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        dma_active
);

`ifdef PPU_ACCESS_LOCK_EN
  localparam bit LOCK_EN = 1'b1;
`else
  localparam bit LOCK_EN = 1'b0;
`endif

  localparam logic [7:0] LAST_IDX = 8'(DMA_LEN - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_READ  = 2'd2,
    ST_WRITE = 2'd3
  } dma_state_t;

  dma_state_t state;
  logic [7:0] idx;
  logic [7:0] dma_reg;
  logic [7:0] src_hi;
  logic [7:0] dbuf;

  logic cpu_req;
  logic cpu_io;
  logic cpu_hram;
  logic cpu_is_dma_reg;
  logic cpu_oam;
  logic cpu_vram;
  logic mode_block;
  logic dma_block;
  logic cpu_mem;
  logic dma_bus;
  logic cpu_grant;
  logic dma_trigger;

  // Decode the CPU address and work out whether it may use the shared bus.
  always_comb begin
    cpu_req        = cpu_rd | cpu_wr;
    cpu_io         = (cpu_addr[15:8] == 8'hFF);
    cpu_hram       = (cpu_addr >= 16'hFF80) && (cpu_addr != 16'hFFFF);
    cpu_is_dma_reg = (cpu_addr == DMA_REG_ADDR);
    cpu_oam        = (cpu_addr >= 16'hFE00) && (cpu_addr <= 16'hFE9F);
    cpu_vram       = (cpu_addr >= 16'h8000) && (cpu_addr <= 16'h9FFF);
    mode_block     = LOCK_EN && ((cpu_oam && ppu_mode[1]) ||
                                 (cpu_vram && (ppu_mode == 2'd3)));
    // The trigger register stays reachable during a copy so a restart works.
    dma_block      = dma_active && !cpu_hram && !cpu_is_dma_reg;
    cpu_mem        = cpu_req && !cpu_io && !mode_block && !dma_block;
    dma_bus        = (state == ST_READ) || (state == ST_WRITE);
    cpu_grant      = cpu_mem && !dma_bus && !ppu_rd;
    dma_trigger    = cpu_wr && cpu_is_dma_reg;
  end

  // Drive the shared bus from the winning requester and route read data back.
  always_comb begin
    mem_addr  = 16'h0000;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_wdata = 8'h00;
    ppu_rdata = 8'hFF;
    cpu_rdata = 8'hFF;
    cpu_wait  = cpu_mem && (dma_bus || ppu_rd);

    if (dma_bus) begin
      if (state == ST_READ) begin
        mem_addr = {src_hi, idx};
        mem_rd   = 1'b1;
      end else begin
        mem_addr  = OAM_BASE + {8'h00, idx};
        mem_wr    = 1'b1;
        mem_wdata = dbuf;
      end
    end else if (ppu_rd) begin
      mem_addr  = ppu_addr;
      mem_rd    = 1'b1;
      ppu_rdata = mem_rdata;
    end else if (cpu_grant) begin
      mem_addr  = cpu_addr;
      mem_rd    = cpu_rd;
      mem_wr    = cpu_wr;
      mem_wdata = cpu_wdata;
    end

    if (cpu_rd) begin
      if (cpu_io) begin
        cpu_rdata = cpu_is_dma_reg ? dma_reg : 8'hFF;
      end else if (cpu_grant) begin
        cpu_rdata = mem_rdata;
      end
    end
  end

  // DMA sequencer; a trigger write overrides whatever step is in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= 8'h00;
      dma_reg    <= 8'h00;
      src_hi     <= 8'h00;
      dbuf       <= 8'h00;
      dma_active <= 1'b0;
    end else begin
      case (state)
        ST_START: state <= ST_READ;
        ST_READ: begin
          dbuf  <= mem_rdata;
          state <= ST_WRITE;
        end
        ST_WRITE: begin
          if (idx == LAST_IDX) begin
            state      <= ST_IDLE;
            dma_active <= 1'b0;
          end else begin
            idx   <= idx + 8'd1;
            state <= ST_READ;
          end
        end
        default: state <= ST_IDLE;
      endcase

      if (dma_trigger) begin
        dma_reg    <= cpu_wdata;
        // Sources above DFxx fall in echo RAM; fold them back onto work RAM.
        src_hi     <= (cpu_wdata > 8'hDF) ? (cpu_wdata - 8'h20) : cpu_wdata;
        idx        <= 8'h00;
        state      <= ST_START;
        dma_active <= 1'b1;
      end
    end
  end

endmodule
